// File: rtl/cc_micro_sequencer.sv
// ----------------------------------------------------------------------------
// cc_micro_sequencer
//   Microprogram sequencer for the ARC control section. Holds the microPC
//   that addresses the (asynchronous) control store and advances it once per
//   committed microinstruction by increment, MIR jump address or opcode
//   decode. Stalls on memory handshakes, supports halt/start and counts
//   committed microinstructions (saturating).
//
// Ports
//   MicroSeq_CLOCK_50     in   system clock, rising edge
//   MicroSeq_RESET_InLow  in   synchronous reset, active low
//   MicroSeq_Start        in   leave IDLE/HALT, execute from current microPC
//   MicroSeq_Halt         in   stop after the microinstruction committing now
//   MicroSeq_Select       in   CS Address Mux select (00 next, 01 jump,
//                              10 decode, 11 illegal)
//   MicroSeq_JumpAddr     in   MIR JUMP ADDR field
//   MicroSeq_Op           in   IR[31:30]
//   MicroSeq_Op3          in   IR[24:19]
//   MicroSeq_MemReq       in   current MIR requests main memory
//   MicroSeq_MemAck       in   main memory completes the request this cycle
//   MicroSeq_CSAddr       out  registered microPC
//   MicroSeq_ExecEn       out  current microinstruction commits this cycle
//   MicroSeq_Running      out  state is RUN or WAIT_MEM
//   MicroSeq_Error        out  sticky: illegal select was committed
//   MicroSeq_Count        out  committed-microinstruction count, saturating
// ----------------------------------------------------------------------------
module cc_micro_sequencer #(
    parameter int DATAWIDTH_ADDR  = 11,
    parameter int DATAWIDTH_SEL   = 2,
    parameter int DATAWIDTH_COUNT = 16
) (
    input  logic                       MicroSeq_CLOCK_50,
    input  logic                       MicroSeq_RESET_InLow,
    input  logic                       MicroSeq_Start,
    input  logic                       MicroSeq_Halt,
    input  logic [DATAWIDTH_SEL-1:0]   MicroSeq_Select,
    input  logic [DATAWIDTH_ADDR-1:0]  MicroSeq_JumpAddr,
    input  logic [1:0]                 MicroSeq_Op,
    input  logic [5:0]                 MicroSeq_Op3,
    input  logic                       MicroSeq_MemReq,
    input  logic                       MicroSeq_MemAck,
    output logic [DATAWIDTH_ADDR-1:0]  MicroSeq_CSAddr,
    output logic                       MicroSeq_ExecEn,
    output logic                       MicroSeq_Running,
    output logic                       MicroSeq_Error,
    output logic [DATAWIDTH_COUNT-1:0] MicroSeq_Count
);

    localparam logic [DATAWIDTH_SEL-1:0] SEL_NEXT    = DATAWIDTH_SEL'(0);
    localparam logic [DATAWIDTH_SEL-1:0] SEL_JUMP    = DATAWIDTH_SEL'(1);
    localparam logic [DATAWIDTH_SEL-1:0] SEL_DECODE  = DATAWIDTH_SEL'(2);
    localparam logic [DATAWIDTH_SEL-1:0] SEL_ILLEGAL = DATAWIDTH_SEL'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_MEM,
        ST_HALT
    } state_t;

    state_t                    state;
    logic                      commit;
    logic [DATAWIDTH_ADDR-1:0] next_addr;
    logic [DATAWIDTH_ADDR-1:0] decode_addr;

    // Opcode decode target: {1, op, op3, 00}
    assign decode_addr = DATAWIDTH_ADDR'({1'b1, MicroSeq_Op, MicroSeq_Op3, 2'b00});

    always_comb begin
        next_addr = MicroSeq_CSAddr + 1'b1;
        case (MicroSeq_Select)
            SEL_JUMP:   next_addr = MicroSeq_JumpAddr;
            SEL_DECODE: next_addr = decode_addr;
            default:    next_addr = MicroSeq_CSAddr + 1'b1;
        endcase
    end

    // Commit is combinational because ExecEn must gate register writes in
    // the same cycle the microinstruction is presented.
    always_comb begin
        commit = 1'b0;
        case (state)
            ST_RUN:      commit = !MicroSeq_MemReq || MicroSeq_MemAck;
            ST_WAIT_MEM: commit = MicroSeq_MemAck;
            default:     commit = 1'b0;
        endcase
    end

    assign MicroSeq_ExecEn  = commit;
    assign MicroSeq_Running = (state == ST_RUN) || (state == ST_WAIT_MEM);

    always_ff @(posedge MicroSeq_CLOCK_50) begin
        if (!MicroSeq_RESET_InLow) begin
            state           <= ST_IDLE;
            MicroSeq_CSAddr <= '0;
            MicroSeq_Error  <= 1'b0;
            MicroSeq_Count  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (MicroSeq_Start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN, ST_WAIT_MEM: begin
                    if (commit) begin
                        MicroSeq_CSAddr <= next_addr;
                        if (MicroSeq_Count != '1) begin
                            MicroSeq_Count <= MicroSeq_Count + 1'b1;
                        end
                        if (MicroSeq_Select == SEL_ILLEGAL) begin
                            MicroSeq_Error <= 1'b1;
                        end
                        state <= MicroSeq_Halt ? ST_HALT : ST_RUN;
                    end else begin
                        // Halt is deliberately ignored while stalled.
                        state <= ST_WAIT_MEM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // SEL_NEXT is covered by the default branch of the next-address mux.
    logic unused_sel_next;
    assign unused_sel_next = ^SEL_NEXT;

endmodule

// File: tb/tb_cc_micro_sequencer.sv
module tb_cc_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, halt, mem_req, mem_ack;
    logic [1:0]  sel, op;
    logic [5:0]  op3;
    logic [10:0] jump_addr;

    logic [10:0] cs_addr, cs_addr4;
    logic        exec_en, running, error;
    logic        exec_en4, running4, error4;
    logic [15:0] count;
    logic [3:0]  count4;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: spec-level view of the sequencer
    int unsigned m_pc, m_cnt;
    bit          m_active;   // executing (RUN or stalled on memory)
    bit          m_wait;     // stalled on memory
    bit          m_err;

    always #5 clk = ~clk;

    cc_micro_sequencer #(
        .DATAWIDTH_ADDR (11),
        .DATAWIDTH_SEL  (2),
        .DATAWIDTH_COUNT(16)
    ) dut (
        .MicroSeq_CLOCK_50   (clk),
        .MicroSeq_RESET_InLow(rst_n),
        .MicroSeq_Start      (start),
        .MicroSeq_Halt       (halt),
        .MicroSeq_Select     (sel),
        .MicroSeq_JumpAddr   (jump_addr),
        .MicroSeq_Op         (op),
        .MicroSeq_Op3        (op3),
        .MicroSeq_MemReq     (mem_req),
        .MicroSeq_MemAck     (mem_ack),
        .MicroSeq_CSAddr     (cs_addr),
        .MicroSeq_ExecEn     (exec_en),
        .MicroSeq_Running    (running),
        .MicroSeq_Error      (error),
        .MicroSeq_Count      (count)
    );

    // Narrow counter instance so saturation is reachable quickly
    cc_micro_sequencer #(
        .DATAWIDTH_ADDR (11),
        .DATAWIDTH_SEL  (2),
        .DATAWIDTH_COUNT(4)
    ) dut4 (
        .MicroSeq_CLOCK_50   (clk),
        .MicroSeq_RESET_InLow(rst_n),
        .MicroSeq_Start      (start),
        .MicroSeq_Halt       (halt),
        .MicroSeq_Select     (sel),
        .MicroSeq_JumpAddr   (jump_addr),
        .MicroSeq_Op         (op),
        .MicroSeq_Op3        (op3),
        .MicroSeq_MemReq     (mem_req),
        .MicroSeq_MemAck     (mem_ack),
        .MicroSeq_CSAddr     (cs_addr4),
        .MicroSeq_ExecEn     (exec_en4),
        .MicroSeq_Running    (running4),
        .MicroSeq_Error      (error4),
        .MicroSeq_Count      (count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check current outputs, advance model.
    task automatic step(input logic r, input logic s, input logic h,
                        input logic [1:0] se, input logic [10:0] j,
                        input logic [1:0] o, input logic [5:0] o3,
                        input logic mr, input logic ma);
        bit          commit;
        int unsigned nxt;
        @(negedge clk);
        rst_n = r; start = s; halt = h; sel = se; jump_addr = j;
        op = o; op3 = o3; mem_req = mr; mem_ack = ma;
        #1;
        commit = m_active && (m_wait ? ma : (!mr || ma));
        case (se)
            2'd1:    nxt = j;
            2'd2:    nxt = 1024 + o * 256 + o3 * 4;
            default: nxt = (m_pc + 1) % 2048;
        endcase
        check("cs_addr", 32'(cs_addr), m_pc);
        check("exec_en", 32'(exec_en), 32'(commit));
        check("running", 32'(running), 32'(m_active));
        check("error",   32'(error),   32'(m_err));
        check("count",   32'(count),   m_cnt);
        check("count4",  32'(count4),  (m_cnt > 15) ? 15 : m_cnt);
        if (!r) begin
            m_pc = 0; m_cnt = 0; m_active = 0; m_wait = 0; m_err = 0;
        end else if (!m_active) begin
            if (s) m_active = 1;
        end else if (commit) begin
            m_pc   = nxt;
            m_cnt  = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            m_err  = m_err | (se == 2'd3);
            m_wait = 0;
            if (h) m_active = 0;
        end else begin
            m_wait = 1;
        end
    endtask

    task automatic go(input logic [1:0] se, input logic [10:0] j, input logic mr, input logic ma);
        step(1'b1, 1'b0, 1'b0, se, j, 2'd0, 6'd0, mr, ma);
    endtask

    task automatic after_edge_check(input string tag, input logic [31:0] got_sel_pc_exp);
        @(posedge clk);
        #1;
        check(tag, 32'(cs_addr), got_sel_pc_exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; sel = 2'd0; jump_addr = '0;
        op = 2'd0; op3 = 6'd0; mem_req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        m_pc = 0; m_cnt = 0; m_active = 0; m_wait = 0; m_err = 0;

        // T1: reset while stalled on memory
        step(1'b1, 1'b1, 1'b0, 2'd0, 11'd0, 2'd0, 6'd0, 1'b0, 1'b0);
        go(2'd0, 11'd0, 1'b1, 1'b0);
        go(2'd0, 11'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 11'd0, 2'd0, 6'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 11'd0, 2'd0, 6'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("t1_pc", 32'(cs_addr), 0);
        check("t1_running", 32'(running), 0);
        check("t1_count", 32'(count), 0);
        check("t1_error", 32'(error), 0);

        // T2: increment with wrap at 2047
        step(1'b1, 1'b1, 1'b0, 2'd0, 11'd0, 2'd0, 6'd0, 1'b0, 1'b0);
        go(2'd1, 11'd2046, 1'b0, 1'b0);
        after_edge_check("t2_jump2046", 2046);
        go(2'd0, 11'd0, 1'b0, 1'b0);
        after_edge_check("t2_2047", 2047);
        go(2'd0, 11'd0, 1'b0, 1'b0);
        after_edge_check("t2_wrap", 0);
        check("t2_count", 32'(count), 3);

        // T3: jump and opcode decode (addcc)
        go(2'd1, 11'd1280, 1'b0, 1'b0);
        after_edge_check("t3_jump", 1280);
        step(1'b1, 1'b0, 1'b0, 2'd2, 11'd0, 2'b10, 6'b010000, 1'b0, 1'b0);
        after_edge_check("t3_decode", 1600);

        // T4: memory stall then ack
        repeat (3) go(2'd0, 11'd0, 1'b1, 1'b0);
        check("t4_count_frozen", 32'(count), 5);
        go(2'd0, 11'd0, 1'b1, 1'b1);
        after_edge_check("t4_advance", 1601);
        check("t4_count", 32'(count), 6);

        // T5: halt in RUN, halt during stall, start wins over halt
        step(1'b1, 1'b0, 1'b1, 2'd0, 11'd0, 2'd0, 6'd0, 1'b0, 1'b0);
        go(2'd0, 11'd0, 1'b0, 1'b0);
        go(2'd0, 11'd0, 1'b0, 1'b0);
        after_edge_check("t5_halt_hold", 1602);
        check("t5_halted", 32'(running), 0);
        step(1'b1, 1'b1, 1'b1, 2'd0, 11'd0, 2'd0, 6'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'd0, 11'd0, 2'd0, 6'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'd0, 11'd0, 2'd0, 6'd0, 1'b1, 1'b0);
        check("t5_stall_running", 32'(running), 1);
        step(1'b1, 1'b0, 1'b1, 2'd0, 11'd0, 2'd0, 6'd0, 1'b1, 1'b1);
        after_edge_check("t5_ack_commit", 1603);
        check("t5_halted2", 32'(running), 0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 11'd0, 2'd0, 6'd0, 1'b0, 1'b0);

        // T6: illegal select is sticky
        go(2'd1, 11'd5, 1'b0, 1'b0);
        after_edge_check("t6_at5", 5);
        go(2'd3, 11'd0, 1'b0, 1'b0);
        after_edge_check("t6_inc", 6);
        check("t6_error", 32'(error), 1);
        repeat (3) go(2'd0, 11'd0, 1'b0, 1'b0);
        check("t6_error_sticky", 32'(error), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(7) == 0),
                 2'($urandom_range(3)),
                 11'($urandom),
                 2'($urandom_range(3)),
                 6'($urandom_range(63)),
                 ($urandom_range(2) == 0),
                 ($urandom_range(1) == 0));
        end
        go(2'd0, 11'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
